// File: rtl/sw_topk_tracker_pkg.sv
// Shared constants and types for the Smith-Waterman top-K result tracker.
// Default widths match the core's result and index widths.
package sw_topk_tracker_pkg;

   localparam int DEF_CALC_BIT  = 16;
   localparam int DEF_T_IDX_BIT = 10;
   localparam int DEF_Q_IDX_BIT = 8;
   localparam int DEF_TOPK      = 4;

   // Width of a rank field able to address TOPK entries, never below one bit.
   function automatic int rank_bits(input int k);
      int b;
      b = $clog2(k);
      return (b < 1) ? 1 : b;
   endfunction

   localparam int DEF_RANK_BIT = rank_bits(DEF_TOPK);

   // Tracker state: IDLE until armed, RUN while the core works,
   // FINISH while the last report drains.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2
   } state_e;

   // One ranked list entry at default widths.
   typedef struct packed {
      logic [DEF_CALC_BIT-1:0]  score;
      logic [DEF_T_IDX_BIT-1:0] t_idx;
   } entry_t;

endpackage

// File: rtl/sw_topk_tracker_if.sv
// Report stream from the top-K tracker to its consumer.
//
// Handshake: the master raises rpt_valid_o with a stable entry and holds
// every payload field unchanged until a cycle in which rpt_ready_i is also
// high; the entry is transferred on that rising edge. The slave may drive
// rpt_ready_i freely; it never changes what is currently presented.
interface sw_topk_tracker_if
   import sw_topk_tracker_pkg::*;
#(
   parameter int CALC_BIT  = DEF_CALC_BIT,
   parameter int T_IDX_BIT = DEF_T_IDX_BIT,
   parameter int Q_IDX_BIT = DEF_Q_IDX_BIT,
   parameter int RANK_BIT  = DEF_RANK_BIT
) ();

   logic                 rpt_valid_o;
   logic                 rpt_ready_i;
   logic [Q_IDX_BIT-1:0] rpt_q_idx_o;
   logic [RANK_BIT-1:0]  rpt_rank_o;
   logic [T_IDX_BIT-1:0] rpt_t_idx_o;
   logic [CALC_BIT-1:0]  rpt_score_o;
   logic                 rpt_last_o;

   modport master (
      output rpt_valid_o,
      output rpt_q_idx_o,
      output rpt_rank_o,
      output rpt_t_idx_o,
      output rpt_score_o,
      output rpt_last_o,
      input  rpt_ready_i
   );

   modport slave (
      input  rpt_valid_o,
      input  rpt_q_idx_o,
      input  rpt_rank_o,
      input  rpt_t_idx_o,
      input  rpt_score_o,
      input  rpt_last_o,
      output rpt_ready_i
   );

endinterface

// File: rtl/sw_topk_insert.sv
// Combinational sorted insert: places a new (score, t_idx) into a
// descending list of up to TOPK entries. Equal scores never displace an
// existing entry, so the earlier target keeps the better rank; when the
// list is full the tail entry falls off.
module sw_topk_insert #(
   parameter int CALC_BIT  = 16,
   parameter int T_IDX_BIT = 10,
   parameter int TOPK      = 4,
   parameter int CNT_BIT   = 3
) (
   input  logic [CALC_BIT-1:0]  score_i     [TOPK],
   input  logic [T_IDX_BIT-1:0] t_idx_i     [TOPK],
   input  logic [CNT_BIT-1:0]   cnt_i,
   input  logic [CALC_BIT-1:0]  new_score_i,
   input  logic [T_IDX_BIT-1:0] new_t_idx_i,
   output logic [CALC_BIT-1:0]  score_o     [TOPK],
   output logic [T_IDX_BIT-1:0] t_idx_o     [TOPK],
   output logic [CNT_BIT-1:0]   cnt_o
);

   // keep[i]: slot i is occupied and outranks (or ties) the new entry.
   // Because the list is sorted, keep is a prefix of ones.
   logic [TOPK-1:0]      keep;
   logic [TOPK-1:0]      prev_keep;
   logic [CALC_BIT-1:0]  sh_score [TOPK];
   logic [T_IDX_BIT-1:0] sh_t_idx [TOPK];

   // Compare every occupied slot against the incoming score.
   always_comb begin
      keep = '0;
      for (int i = 0; i < TOPK; i++) begin
         keep[i] = (CNT_BIT'(i) < cnt_i) && (score_i[i] >= new_score_i);
      end
   end

   // Build the "one slot down" view of the list and the neighbour keep flags.
   always_comb begin
      prev_keep    = '0;
      prev_keep[0] = 1'b1;
      sh_score[0]  = '0;
      sh_t_idx[0]  = '0;
      for (int i = 1; i < TOPK; i++) begin
         prev_keep[i] = keep[i-1];
         sh_score[i]  = score_i[i-1];
         sh_t_idx[i]  = t_idx_i[i-1];
      end
   end

   // Per slot: keep the old entry, take the new one at the boundary, or shift.
   always_comb begin
      for (int i = 0; i < TOPK; i++) begin
         score_o[i] = score_i[i];
         t_idx_o[i] = t_idx_i[i];
         if (!keep[i]) begin
            if (prev_keep[i]) begin
               score_o[i] = new_score_i;
               t_idx_o[i] = new_t_idx_i;
            end else begin
               score_o[i] = sh_score[i];
               t_idx_o[i] = sh_t_idx[i];
            end
         end
      end
   end

   // A full list stays full whether the new entry landed or was dropped.
   always_comb begin
      cnt_o = cnt_i;
      if (cnt_i < CNT_BIT'(TOPK)) begin
         cnt_o = cnt_i + CNT_BIT'(1);
      end
   end

endmodule

// File: rtl/sw_topk_tracker.sv
// Top-K result tracker for the Smith-Waterman core. Keeps target/query
// counters, a ranked working list per query, and a single-entry report
// buffer that is streamed out rank by rank on a valid/ready interface.
module sw_topk_tracker
   import sw_topk_tracker_pkg::*;
#(
   parameter int CALC_BIT  = DEF_CALC_BIT,
   parameter int T_IDX_BIT = DEF_T_IDX_BIT,
   parameter int Q_IDX_BIT = DEF_Q_IDX_BIT,
   parameter int TOPK      = DEF_TOPK,
   parameter int RANK_BIT  = DEF_RANK_BIT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_i,
   input  logic                sw_busy_i,
   input  logic                valid_i,
   input  logic [CALC_BIT-1:0] result_i,
   input  logic                change_q_i,
   sw_topk_tracker_if.master   rpt,
   output logic                overflow_o,
   output logic                done_o,
   output state_e              dbg_state_o
);

   localparam int CNT_BIT = $clog2(TOPK + 1);

   // Run control.
   state_e               state_q;
   logic                 run_first_q;
   logic                 done_q;

   // Index counters.
   logic [T_IDX_BIT-1:0] t_idx_q;
   logic [Q_IDX_BIT-1:0] q_idx_q;

   // Working list for the query in progress.
   logic [CALC_BIT-1:0]  lst_score_q [TOPK];
   logic [T_IDX_BIT-1:0] lst_t_idx_q [TOPK];
   logic [CNT_BIT-1:0]   lst_cnt_q;

   // Report buffer holding one finished query.
   logic [CALC_BIT-1:0]  buf_score_q [TOPK];
   logic [T_IDX_BIT-1:0] buf_t_idx_q [TOPK];
   logic [CNT_BIT-1:0]   buf_cnt_q;
   logic [Q_IDX_BIT-1:0] buf_q_idx_q;
   logic                 buf_full_q;
   logic [RANK_BIT-1:0]  rd_ptr_q;
   logic                 overflow_q;

   // Insert network results.
   logic [CALC_BIT-1:0]  ins_score [TOPK];
   logic [T_IDX_BIT-1:0] ins_t_idx [TOPK];
   logic [CNT_BIT-1:0]   ins_cnt;

   logic take;
   logic snap;
   logic rpt_fire;
   logic rpt_last;
   logic buf_can_load;

   // Results are only accepted once armed; a restart pulse wins over data.
   assign take         = valid_i && (state_q != ST_IDLE) && !start_i;
   assign snap         = take && change_q_i;
   assign rpt_fire     = buf_full_q && rpt.rpt_ready_i;
   assign rpt_last     = buf_full_q && (CNT_BIT'(rd_ptr_q) == (buf_cnt_q - CNT_BIT'(1)));
   // The buffer may refill in the same cycle its final entry is accepted.
   assign buf_can_load = !buf_full_q || (rpt_fire && rpt_last);

   sw_topk_insert #(
      .CALC_BIT  (CALC_BIT),
      .T_IDX_BIT (T_IDX_BIT),
      .TOPK      (TOPK),
      .CNT_BIT   (CNT_BIT)
   ) u_insert (
      .score_i     (lst_score_q),
      .t_idx_i     (lst_t_idx_q),
      .cnt_i       (lst_cnt_q),
      .new_score_i (result_i),
      .new_t_idx_i (t_idx_q),
      .score_o     (ins_score),
      .t_idx_o     (ins_t_idx),
      .cnt_o       (ins_cnt)
   );

   // Run FSM with a registered completion pulse. The busy line is ignored
   // on the first RUN cycle because the core has not raised it yet.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         run_first_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start_i) begin
            state_q     <= ST_RUN;
            run_first_q <= 1'b1;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  state_q <= ST_IDLE;
               end
               ST_RUN: begin
                  if (run_first_q) begin
                     run_first_q <= 1'b0;
                  end else if (!sw_busy_i) begin
                     state_q <= ST_FINISH;
                  end
               end
               ST_FINISH: begin
                  if (!buf_full_q && !snap) begin
                     state_q <= ST_IDLE;
                     done_q  <= 1'b1;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // Index counters and the working list; a query end clears the list.
   always_ff @(posedge clk) begin
      if (!rst_n || start_i) begin
         t_idx_q   <= '0;
         q_idx_q   <= '0;
         lst_cnt_q <= '0;
         for (int i = 0; i < TOPK; i++) begin
            lst_score_q[i] <= '0;
            lst_t_idx_q[i] <= '0;
         end
      end else if (take) begin
         if (change_q_i) begin
            t_idx_q   <= '0;
            q_idx_q   <= q_idx_q + Q_IDX_BIT'(1);
            lst_cnt_q <= '0;
            for (int i = 0; i < TOPK; i++) begin
               lst_score_q[i] <= '0;
               lst_t_idx_q[i] <= '0;
            end
         end else begin
            t_idx_q   <= t_idx_q + T_IDX_BIT'(1);
            lst_cnt_q <= ins_cnt;
            for (int i = 0; i < TOPK; i++) begin
               lst_score_q[i] <= ins_score[i];
               lst_t_idx_q[i] <= ins_t_idx[i];
            end
         end
      end
   end

   // Report buffer: drain rank by rank, load the final list on a query end,
   // and flag a sticky overflow when a finished query finds it occupied.
   always_ff @(posedge clk) begin
      if (!rst_n || start_i) begin
         buf_cnt_q   <= '0;
         buf_q_idx_q <= '0;
         buf_full_q  <= 1'b0;
         rd_ptr_q    <= '0;
         overflow_q  <= 1'b0;
         for (int i = 0; i < TOPK; i++) begin
            buf_score_q[i] <= '0;
            buf_t_idx_q[i] <= '0;
         end
      end else begin
         if (rpt_fire) begin
            if (rpt_last) begin
               buf_full_q <= 1'b0;
            end else begin
               rd_ptr_q <= rd_ptr_q + RANK_BIT'(1);
            end
         end
         if (snap) begin
            if (buf_can_load) begin
               buf_full_q  <= 1'b1;
               rd_ptr_q    <= '0;
               buf_cnt_q   <= ins_cnt;
               buf_q_idx_q <= q_idx_q;
               for (int i = 0; i < TOPK; i++) begin
                  buf_score_q[i] <= ins_score[i];
                  buf_t_idx_q[i] <= ins_t_idx[i];
               end
            end else begin
               overflow_q <= 1'b1;
            end
         end
      end
   end

   assign rpt.rpt_valid_o = buf_full_q;
   assign rpt.rpt_q_idx_o = buf_q_idx_q;
   assign rpt.rpt_rank_o  = rd_ptr_q;
   assign rpt.rpt_t_idx_o = buf_t_idx_q[rd_ptr_q];
   assign rpt.rpt_score_o = buf_score_q[rd_ptr_q];
   assign rpt.rpt_last_o  = rpt_last;

   assign overflow_o  = overflow_q;
   assign done_o      = done_q;
   assign dbg_state_o = state_q;

endmodule
